// File: rtl/nco_pkg.sv
// Shared constants for the dual-tone NCO, plus the elaboration-time generator for the
// quarter-wave sine table (fixed-point Taylor series, rounded to Q0.15).
package nco_pkg;

    localparam int PHASE_W    = 24;
    localparam int LUT_ADDR_W = 8;
    localparam int SAMPLE_W   = 16;
    localparam int SCALED_W   = SAMPLE_W + 1;
    localparam int SUM_W      = SAMPLE_W + 2;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    localparam int     FRAC_W = 30;
    localparam longint PI_Q30 = 64'sd3373259426;

    // Entry k = round(32767 * sin(pi/2 * (k + 0.5) / 2^addr_w)); Q30 keeps every product inside 64 bits.
    function automatic logic [SAMPLE_W-1:0] sine_entry(input int k, input int addr_w);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint scaled;
        x    = (PI_Q30 * longint'(2 * k + 1)) / (longint'(1) <<< (addr_w + 2));
        x2   = (x * x) >>> FRAC_W;
        term = x;
        sum  = x;
        for (int n = 1; n <= 10; n++) begin
            term = -((term * x2) >>> FRAC_W) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        scaled = (sum * 32767 + (longint'(1) <<< (FRAC_W - 1))) >>> FRAC_W;
        return SAMPLE_W'(scaled);
    endfunction

endpackage

// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine ROM with a registered read port; quadrant folding is done by the parent.
module sine_quarter_lut
    import nco_pkg::*;
#(
    parameter int ADDR_W = nco_pkg::LUT_ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   addr,
    output logic [SAMPLE_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [SAMPLE_W-1:0] rom [DEPTH];
    logic [SAMPLE_W-1:0] rdata_d;
    logic [SAMPLE_W-1:0] rdata_q;

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam logic [SAMPLE_W-1:0] ENTRY = sine_entry(k, ADDR_W);
        assign rom[k] = ENTRY;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = rom[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dual_tone_nco.sv
// Two-tone NCO producing a saturated composite sample on every divider tick (3-cycle pipeline).
// Define NCO_PHASE_DITHER_EN to add LFSR phase dither ahead of table truncation.
module dual_tone_nco #(
    parameter int PHASE_W    = nco_pkg::PHASE_W,
    parameter int LUT_ADDR_W = nco_pkg::LUT_ADDR_W
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic [15:0]                          sample_div,
    input  logic [PHASE_W-1:0]                   ftw1,
    input  logic [PHASE_W-1:0]                   ftw2,
    input  logic [15:0]                          amp1,
    input  logic [15:0]                          amp2,
    output logic signed [nco_pkg::SAMPLE_W-1:0]  x_out,
    output logic                                 x_valid
);

    import nco_pkg::*;

    localparam int QIDX_W = LUT_ADDR_W + 2;

    logic [PHASE_W-1:0] acc1_d, acc1_q;
    logic [PHASE_W-1:0] acc2_d, acc2_q;
    logic [15:0]        div_cnt_d, div_cnt_q;
    logic               tick;

    logic [QIDX_W-1:0]     ptop1, ptop2;
    logic [LUT_ADDR_W-1:0] addr1, addr2;
    logic [SAMPLE_W-1:0]   lut1, lut2;

    logic s1_valid_d, s1_valid_q;
    logic s1_neg1_d, s1_neg1_q;
    logic s1_neg2_d, s1_neg2_q;

    logic signed [SCALED_W-1:0]   sine1, sine2;
    logic signed [2*SCALED_W-1:0] mult1, mult2;
    logic signed [SCALED_W-1:0]   s2_tone1_d, s2_tone1_q;
    logic signed [SCALED_W-1:0]   s2_tone2_d, s2_tone2_q;
    logic                         s2_valid_d, s2_valid_q;

    logic signed [SUM_W-1:0]    sum;
    logic signed [SAMPLE_W-1:0] x_out_d, x_out_q;
    logic                       x_valid_d, x_valid_q;

    assign tick = enable && (div_cnt_q >= sample_div);

    always_comb begin
        div_cnt_d = div_cnt_q;
        acc1_d    = acc1_q;
        acc2_d    = acc2_q;
        if (enable) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 16'd1;
        end
        if (tick) begin
            acc1_d = acc1_q + ftw1;
            acc2_d = acc2_q + ftw2;
        end
    end

`ifdef NCO_PHASE_DITHER_EN
    localparam int DITHER_W = PHASE_W - LUT_ADDR_W - 2;

    logic [15:0]        lfsr_d, lfsr_q;
    logic [PHASE_W-1:0] dither;

    always_comb begin
        dither = PHASE_W'(lfsr_q) & ((PHASE_W'(1) << DITHER_W) - PHASE_W'(1));
        lfsr_d = lfsr_q;
        if (tick) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
        ptop1 = QIDX_W'((acc1_q + dither) >> DITHER_W);
        ptop2 = QIDX_W'((acc2_q + dither) >> DITHER_W);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    always_comb begin
        ptop1 = acc1_q[PHASE_W-1 -: QIDX_W];
        ptop2 = acc2_q[PHASE_W-1 -: QIDX_W];
    end
`endif

    // Odd quadrants walk the table backwards; the upper half-cycle is negated after the read.
    always_comb begin
        addr1      = ptop1[QIDX_W-2] ? ~ptop1[LUT_ADDR_W-1:0] : ptop1[LUT_ADDR_W-1:0];
        addr2      = ptop2[QIDX_W-2] ? ~ptop2[LUT_ADDR_W-1:0] : ptop2[LUT_ADDR_W-1:0];
        s1_valid_d = tick;
        s1_neg1_d  = s1_neg1_q;
        s1_neg2_d  = s1_neg2_q;
        if (tick) begin
            s1_neg1_d = ptop1[QIDX_W-1];
            s1_neg2_d = ptop2[QIDX_W-1];
        end
    end

    sine_quarter_lut #(
        .ADDR_W (LUT_ADDR_W)
    ) u_lut1 (
        .clk   (clk),
        .reset (reset),
        .rd_en (tick),
        .addr  (addr1),
        .rdata (lut1)
    );

    sine_quarter_lut #(
        .ADDR_W (LUT_ADDR_W)
    ) u_lut2 (
        .clk   (clk),
        .reset (reset),
        .rd_en (tick),
        .addr  (addr2),
        .rdata (lut2)
    );

    always_comb begin
        sine1      = s1_neg1_q ? -$signed({1'b0, lut1}) : $signed({1'b0, lut1});
        sine2      = s1_neg2_q ? -$signed({1'b0, lut2}) : $signed({1'b0, lut2});
        mult1      = (2*SCALED_W)'(sine1) * (2*SCALED_W)'($signed({1'b0, amp1}));
        mult2      = (2*SCALED_W)'(sine2) * (2*SCALED_W)'($signed({1'b0, amp2}));
        s2_valid_d = s1_valid_q;
        s2_tone1_d = s2_tone1_q;
        s2_tone2_d = s2_tone2_q;
        if (s1_valid_q) begin
            s2_tone1_d = SCALED_W'(mult1 >>> 15);
            s2_tone2_d = SCALED_W'(mult2 >>> 15);
        end
    end

    always_comb begin
        sum       = SUM_W'(s2_tone1_q) + SUM_W'(s2_tone2_q);
        x_valid_d = s2_valid_q;
        x_out_d   = x_out_q;
        if (s2_valid_q) begin
            if (sum > SUM_W'(SAT_MAX)) begin
                x_out_d = SAMPLE_W'(SAT_MAX);
            end else if (sum < SUM_W'(SAT_MIN)) begin
                x_out_d = SAMPLE_W'(SAT_MIN);
            end else begin
                x_out_d = SAMPLE_W'(sum);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc1_q     <= '0;
            acc2_q     <= '0;
            div_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_neg1_q  <= 1'b0;
            s1_neg2_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_tone1_q <= '0;
            s2_tone2_q <= '0;
            x_valid_q  <= 1'b0;
            x_out_q    <= '0;
        end else begin
            acc1_q     <= acc1_d;
            acc2_q     <= acc2_d;
            div_cnt_q  <= div_cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_neg1_q  <= s1_neg1_d;
            s1_neg2_q  <= s1_neg2_d;
            s2_valid_q <= s2_valid_d;
            s2_tone1_q <= s2_tone1_d;
            s2_tone2_q <= s2_tone2_d;
            x_valid_q  <= x_valid_d;
            x_out_q    <= x_out_d;
        end
    end

    assign x_out   = x_out_q;
    assign x_valid = x_valid_q;

endmodule
